// File: rtl/mdu_wb_arbiter_pkg.sv
// Shared MDU result types: writeback payload and the arbiter's source select.
package mdu_wb_arbiter_pkg;

    localparam int ROB_WIDTH = 6;

    typedef struct packed {
        logic [ROB_WIDTH-1:0] reg_id;
        logic [31:0]          data;
    } mdu_o_t;

    typedef enum logic {
        MDU_WB_MUL = 1'b0,
        MDU_WB_DIV = 1'b1
    } mdu_wb_sel_e;

endpackage

// File: rtl/mdu_wb_arbiter_res_fifo.sv
// Per-source result FIFO, DEPTH entries; head visible one cycle after push, no bypass.
// Pushes are ignored while full, even when a pop happens in the same cycle.
module mdu_res_fifo
    import mdu_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   i_push,
    input  mdu_o_t i_din,
    input  logic   i_pop,
    output logic   o_full,
    output logic   o_empty,
    output mdu_o_t o_head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    mdu_o_t        r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;

    logic w_push;
    logic w_pop;
    logic w_clr;

    assign w_clr   = !rst_n || flush;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // simultaneous push and pop leaves the occupancy unchanged
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!w_clr && w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

endmodule

// File: rtl/mdu_wb_arbiter.sv
// Merges mul/div result streams into one registered writeback stream, round-robin on contention.
// Result accepted at edge N is visible after edge N+1; output holds while wb_valid_o && !wb_ready_i.
module mdu_wb_arbiter
    import mdu_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  mdu_o_t mul_res_i,
    input  logic   mul_valid_i,
    output logic   mul_ready_o,
    input  mdu_o_t div_res_i,
    input  logic   div_valid_i,
    output logic   div_ready_o,
    output mdu_o_t wb_res_o,
    output logic   wb_valid_o,
    input  logic   wb_ready_i
);

    logic        w_mul_full;
    logic        w_mul_empty;
    mdu_o_t      w_mul_head;
    logic        w_div_full;
    logic        w_div_empty;
    mdu_o_t      w_div_head;

    logic        w_mul_push;
    logic        w_div_push;
    logic        w_mul_pop;
    logic        w_div_pop;
    logic        w_load;
    logic        w_any;
    mdu_wb_sel_e w_grant;
    mdu_o_t      w_head;

    mdu_o_t      r_wb_res;
    logic        r_wb_valid;
    mdu_wb_sel_e r_last_grant;

    assign mul_ready_o = !w_mul_full;
    assign div_ready_o = !w_div_full;
    assign w_mul_push  = mul_valid_i && mul_ready_o;
    assign w_div_push  = div_valid_i && div_ready_o;

    mdu_res_fifo #(.DEPTH(DEPTH)) u_mul_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .i_push  (w_mul_push),
        .i_din   (mul_res_i),
        .i_pop   (w_mul_pop),
        .o_full  (w_mul_full),
        .o_empty (w_mul_empty),
        .o_head  (w_mul_head)
    );

    mdu_res_fifo #(.DEPTH(DEPTH)) u_div_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .i_push  (w_div_push),
        .i_din   (div_res_i),
        .i_pop   (w_div_pop),
        .o_full  (w_div_full),
        .o_empty (w_div_empty),
        .o_head  (w_div_head)
    );

    // on contention the source that did not win last time gets the slot
    always_comb begin
        w_grant = MDU_WB_MUL;
        if (!w_mul_empty && !w_div_empty) begin
            w_grant = (r_last_grant == MDU_WB_MUL) ? MDU_WB_DIV : MDU_WB_MUL;
        end else if (!w_div_empty) begin
            w_grant = MDU_WB_DIV;
        end
    end

    assign w_load    = !r_wb_valid || wb_ready_i;
    assign w_any     = !w_mul_empty || !w_div_empty;
    assign w_mul_pop = w_load && !w_mul_empty && (w_grant == MDU_WB_MUL);
    assign w_div_pop = w_load && !w_div_empty && (w_grant == MDU_WB_DIV);
    assign w_head    = (w_grant == MDU_WB_DIV) ? w_div_head : w_mul_head;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wb_res     <= '0;
            r_wb_valid   <= 1'b0;
            r_last_grant <= MDU_WB_DIV;
        end else if (w_load) begin
            if (w_any) begin
                r_wb_res     <= w_head;
                r_wb_valid   <= 1'b1;
                r_last_grant <= w_grant;
            end else begin
                r_wb_valid   <= 1'b0;
            end
        end
    end

    assign wb_res_o   = r_wb_res;
    assign wb_valid_o = r_wb_valid;

endmodule

// File: tb/tb_mdu_wb_arbiter.sv
module tb_mdu_wb_arbiter;
    import mdu_wb_arbiter_pkg::*;

    localparam int DEPTH = 2;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   flush = 1'b0;
    mdu_o_t mul_res_i = '0;
    logic   mul_valid_i = 1'b0;
    logic   mul_ready_o;
    mdu_o_t div_res_i = '0;
    logic   div_valid_i = 1'b0;
    logic   div_ready_o;
    mdu_o_t wb_res_o;
    logic   wb_valid_o;
    logic   wb_ready_i = 1'b0;

    always #5 clk = ~clk;

    mdu_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .mul_res_i   (mul_res_i),
        .mul_valid_i (mul_valid_i),
        .mul_ready_o (mul_ready_o),
        .div_res_i   (div_res_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .wb_res_o    (wb_res_o),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i)
    );

    int vectors = 0;
    int errs    = 0;

    // reference model: two queues plus the output slot and who won last
    mdu_o_t mq[$];
    mdu_o_t dq[$];
    logic   m_valid = 1'b0;
    mdu_o_t m_res   = '0;
    logic   m_last  = 1'b1;

    logic   acc_mul;
    logic   acc_div;
    logic   cap_en = 1'b0;
    mdu_o_t cap[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic mv, input mdu_o_t md, input logic dv, input mdu_o_t dd,
                        input logic wr, input logic fl, input logic rs);
        mul_valid_i = mv;
        mul_res_i   = md;
        div_valid_i = dv;
        div_res_i   = dd;
        wb_ready_i  = wr;
        flush       = fl;
        rst_n       = rs;
        if (cap_en && rs && !fl && wr && wb_valid_o) cap.push_back(wb_res_o);
        acc_mul = mv && (mq.size() < DEPTH) && rs && !fl;
        acc_div = dv && (dq.size() < DEPTH) && rs && !fl;
        @(posedge clk);
        if (!rs || fl) begin
            mq.delete();
            dq.delete();
            m_valid = 1'b0;
            m_res   = '0;
            m_last  = 1'b1;
        end else begin
            if (!m_valid || wr) begin
                if (mq.size() > 0 && (dq.size() == 0 || m_last == 1'b1)) begin
                    m_res   = mq.pop_front();
                    m_valid = 1'b1;
                    m_last  = 1'b0;
                end else if (dq.size() > 0) begin
                    m_res   = dq.pop_front();
                    m_valid = 1'b1;
                    m_last  = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (acc_mul) mq.push_back(md);
            if (acc_div) dq.push_back(dd);
        end
        #1;
        check("wb_valid", 64'(wb_valid_o), 64'(m_valid));
        check("wb_res", 64'(wb_res_o), 64'(m_res));
        check("mul_ready", 64'(mul_ready_o), 64'(mq.size() < DEPTH));
        check("div_ready", 64'(div_ready_o), 64'(dq.size() < DEPTH));
    endtask

    function automatic mdu_o_t mk(input int id, input logic [31:0] d);
        mdu_o_t r;
        r.reg_id = ROB_WIDTH'(id);
        r.data   = d;
        return r;
    endfunction

    initial begin
        mdu_o_t z;
        mdu_o_t a;
        mdu_o_t b;
        int mi;
        int di;
        z = '0;

        // reset
        step(1'b0, z, 1'b0, z, 1'b1, 1'b0, 1'b0);
        step(1'b0, z, 1'b0, z, 1'b1, 1'b0, 1'b0);
        check("rst_valid", 64'(wb_valid_o), 64'(0));
        check("rst_res", 64'(wb_res_o), 64'(0));
        check("rst_mul_rdy", 64'(mul_ready_o), 64'(1));
        check("rst_div_rdy", 64'(div_ready_o), 64'(1));

        // single source
        a = mk(5, 32'h1234_5678);
        step(1'b1, a, 1'b0, z, 1'b1, 1'b0, 1'b1);
        check("single_e0_valid", 64'(wb_valid_o), 64'(0));
        step(1'b0, z, 1'b0, z, 1'b1, 1'b0, 1'b1);
        check("single_e1_valid", 64'(wb_valid_o), 64'(1));
        check("single_e1_res", 64'(wb_res_o), 64'(a));
        step(1'b0, z, 1'b0, z, 1'b1, 1'b0, 1'b1);
        check("single_e2_valid", 64'(wb_valid_o), 64'(0));

        // contention from a fresh reset so mul wins first
        step(1'b0, z, 1'b0, z, 1'b1, 1'b0, 1'b0);
        cap.delete();
        cap_en = 1'b1;
        mi = 0;
        di = 0;
        for (int c = 0; c < 14; c++) begin
            step(mi < 4, mk(mi, 32'hA000_0000 + 32'(mi)), di < 4, mk(8 + di, 32'hD000_0000 + 32'(di)),
                 1'b1, 1'b0, 1'b1);
            if (acc_mul) mi++;
            if (acc_div) di++;
        end
        check("cont_count", 64'(cap.size()), 64'(8));
        for (int k = 0; k < 4; k++) begin
            if (cap.size() > 2 * k + 1) begin
                check("cont_mul", 64'(cap[2*k]), 64'(mk(k, 32'hA000_0000 + 32'(k))));
                check("cont_div", 64'(cap[2*k+1]), 64'(mk(8 + k, 32'hD000_0000 + 32'(k))));
            end
        end

        // backpressure: mul pushes 3 while the consumer stalls
        cap.delete();
        mi = 0;
        for (int c = 0; c < 6; c++) begin
            step(mi < 3, mk(20 + mi, 32'hB000_0000 + 32'(mi)), 1'b0, z, 1'b0, 1'b0, 1'b1);
            if (acc_mul) mi++;
        end
        check("bp_hold_res", 64'(wb_res_o), 64'(mk(20, 32'hB000_0000)));
        check("bp_hold_valid", 64'(wb_valid_o), 64'(1));
        check("bp_mul_rdy", 64'(mul_ready_o), 64'(0));
        for (int c = 0; c < 4; c++) step(1'b0, z, 1'b0, z, 1'b1, 1'b0, 1'b1);
        check("bp_count", 64'(cap.size()), 64'(3));
        for (int k = 0; k < 3; k++) begin
            if (cap.size() > k) check("bp_order", 64'(cap[k]), 64'(mk(20 + k, 32'hB000_0000 + 32'(k))));
        end

        // flush with 2 mul + 1 div queued and the output valid
        step(1'b1, mk(30, 32'h3000), 1'b1, mk(40, 32'h4000), 1'b0, 1'b0, 1'b1);
        step(1'b1, mk(31, 32'h3001), 1'b0, z, 1'b0, 1'b0, 1'b1);
        step(1'b0, z, 1'b1, mk(41, 32'h4001), 1'b0, 1'b0, 1'b1);
        check("pre_flush_valid", 64'(wb_valid_o), 64'(1));
        check("pre_flush_mul_rdy", 64'(mul_ready_o), 64'(0));
        step(1'b1, mk(32, 32'h3002), 1'b1, mk(42, 32'h4002), 1'b0, 1'b1, 1'b1);
        check("flush_valid", 64'(wb_valid_o), 64'(0));
        check("flush_mul_rdy", 64'(mul_ready_o), 64'(1));
        check("flush_div_rdy", 64'(div_ready_o), 64'(1));
        cap.delete();
        b = mk(33, 32'hCAFE_F00D);
        step(1'b1, b, 1'b0, z, 1'b1, 1'b0, 1'b1);
        step(1'b0, z, 1'b0, z, 1'b1, 1'b0, 1'b1);
        check("post_flush_res", 64'(wb_res_o), 64'(b));
        step(1'b0, z, 1'b0, z, 1'b1, 1'b0, 1'b1);
        check("post_flush_count", 64'(cap.size()), 64'(1));

        // pointer wrap-around through the mul FIFO
        step(1'b0, z, 1'b0, z, 1'b1, 1'b0, 1'b0);
        cap.delete();
        for (int k = 0; k < 10; k++) step(1'b1, mk(k, 32'h5000 + 32'(k)), 1'b0, z, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, z, 1'b0, z, 1'b1, 1'b0, 1'b1);
        check("wrap_count", 64'(cap.size()), 64'(10));
        for (int k = 0; k < 10; k++) begin
            if (cap.size() > k) check("wrap_order", 64'(cap[k]), 64'(mk(k, 32'h5000 + 32'(k))));
        end
        cap_en = 1'b0;

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), mk(int'($urandom_range(0, 63)), $urandom),
                 1'($urandom_range(0, 1)), mk(int'($urandom_range(0, 63)), $urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/mdu_wb_arbiter.md
# mdu_wb_arbiter

Result-side merge stage of the multiply/divide unit. Consumes the `mdu_o_t` result streams of the multiplier and divider, buffers each in a small per-source FIFO, and presents one registered writeback stream to the ROB/writeback bus. Round-robin arbitration between the two sources prevents starvation.

## Interface

Parameters:
- `DEPTH`, 2: entries per source FIFO. Power of two, ≥2.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; synchronous, active-low
- `flush`  in  1  pipeline flush; synchronous, same effect as reset
- `mul_res_i`  in  `mdu_o_t`  multiplier result (`reg_id` `ROB_WIDTH` bits, `data` 32 bits)
- `mul_valid_i`  in  1  multiplier result valid
- `mul_ready_o`  out  1  multiplier FIFO can accept
- `div_res_i`  in  `mdu_o_t`  divider result
- `div_valid_i`  in  1  divider result valid
- `div_ready_o`  out  1  divider FIFO can accept
- `wb_res_o`  out  `mdu_o_t`  writeback result, registered
- `wb_valid_o`  out  1  writeback valid, registered
- `wb_ready_i`  in  1  writeback consumer accepts

## Operation

- Enqueue: source X pushes when `X_valid_i && X_ready_o`. `X_ready_o = (count_X < DEPTH)`; depends on state only, never on `X_valid_i` or `wb_ready_i`.
- Full FIFO: no enqueue, even if a dequeue happens in the same cycle. No bypass from input to output.
- Output register load: enabled when `!wb_valid_o || wb_ready_i`.
- With load enabled:
  - If any FIFO is non-empty, pop one head into `wb_res_o` and set `wb_valid_o=1`.
  - If both FIFOs are empty, set `wb_valid_o=0`. `wb_res_o` holds its value.
- Arbitration: `last_grant` is 1 bit (0=mul, 1=div).
  - Only one source non-empty: grant that source.
  - Both non-empty: grant the source ≠ `last_grant`.
  - `last_grant` updates only on an actual pop.
- Hold: while `wb_valid_o && !wb_ready_i`, `wb_res_o` and `wb_valid_o` are stable.
- Per-source order is FIFO. No ordering is guaranteed across sources.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Counts are `$clog2(DEPTH)+1` bits.
- Push and pop on the same FIFO in one cycle leaves the count unchanged, with both pointers advancing.
- Reset or flush (`!rst_n || flush`), with priority over everything else:
  - counts, pointers ← 0
  - `wb_valid_o` ← 0, `wb_res_o` ← 0
  - `last_grant` ← 1 (mul wins first contention)
  - Inputs presented in that cycle are dropped.
- Reset values of outputs: `wb_valid_o=0`, `wb_res_o=0`, `mul_ready_o=1`, `div_ready_o=1` (after the reset edge).

## Timing

- Latency: a result accepted at edge N appears on `wb_*` after edge N+1, provided the output register is free and the entry wins arbitration.
- Throughput: one writeback per cycle in aggregate. Each source sustains one per cycle when the other is idle.
- Contention: both FIFOs non-empty with `wb_ready_i=1` gives strict alternation: mul, div, mul, …
- A flush asserted mid-stream clears all in-flight entries on the same edge. The next cycle shows `wb_valid_o=0` and both readies at 1.

## Structure

- `mdu_o_t` and `ROB_WIDTH` come from the shared defines package; no new typedefs are added.
- The `mdu_wb_sel_e` (MUL/DIV) enum for `last_grant` goes in the shared package.
- One sub-module `mdu_res_fifo`, parameterized by DEPTH and handling `mdu_o_t` with `push`, `pop`, `full`, `empty` and `head`, is instantiated twice. The top level holds the arbiter and the output register.

## Test plan

- Reset: hold `rst_n=0` for 2 cycles, then release. Required: `wb_valid_o=0`, `wb_res_o=0`, both readies =1.
- Single source: push mul `{reg_id=5, data=0x1234_5678}` at edge 0 with `wb_ready_i=1`. Required: `wb_valid_o=1` with that payload after edge 1, and `wb_valid_o=0` after edge 2.
- Contention: both sources push every cycle for 4 cycles, mul `reg_id` 0..3 and div `reg_id` 8..11, with `wb_ready_i=1`. Required:
  - output order mul0, div8, mul1, div9, …
  - each ready deasserts while its FIFO count is 2
  - no entry is lost or duplicated.
- Backpressure: `wb_ready_i=0` while mul pushes 3 results. Required:
  - the first result is held stable on `wb_res_o`
  - FIFO holds 2, `mul_ready_o=0`
  - on release, all 3 results drain in order over 3 cycles.
- Flush: with 2 mul entries queued, 1 div entry queued and `wb_valid_o=1`, assert `flush` for 1 cycle. Required:
  - the next cycle shows `wb_valid_o=0` and both readies at 1
  - a subsequent push emerges alone after 1 cycle.
- Wrap-around: run 10 sequential pushes and pops through one FIFO with `DEPTH=2`. Required: data order is preserved across pointer wrap and the count never exceeds 2.
